// File: rtl/uart_model_pkg.sv
// uart_model_pkg: shared state encoding and configuration helpers for the
// co-simulation UART transmitter.
`default_nettype none

package uart_model_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START      = 3'd1,
    ST_DATA       = 3'd2,
    ST_STOP       = 3'd3,
    ST_BREAK      = 3'd4,
    ST_BREAK_IDLE = 3'd5
  } tx_state_e;

  function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

  function automatic bit cfg_ok(input int payload_bits, input int stop_bits,
                                input int cpb, input int fifo_depth);
    bit pow2;
    pow2 = (fifo_depth >= 2) && ((fifo_depth & (fifo_depth - 1)) == 0);
    return (payload_bits >= 5) && (payload_bits <= 8) &&
           (stop_bits >= 1) && (stop_bits <= 2) &&
           (cpb >= 2) && pow2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_model_if.sv
// uart_tx_model_if: valid/ready byte push channel into the UART transmitter.
`default_nettype none

interface uart_tx_model_if #(
  parameter int PAYLOAD_BITS = 8
);
  logic                    tx_valid;
  logic [PAYLOAD_BITS-1:0] tx_data;
  logic                    tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous first-word-fall-through FIFO with occupancy output.
`default_nettype none

module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             push_ok;
  logic             pop_ok;

  // Full is decoded from the pre-edge level, so a push arriving with a pop
  // while full is still refused.
  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_model.sv
// uart_tx_model: FIFO-fed UART transmitter (start, LSB-first data, stop) with
// line-break generation, for driving a DUT receive pin in co-simulation.
`default_nettype none

module uart_tx_model
  import uart_model_pkg::*;
#(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16,
  parameter int BREAK_BITS   = 20
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        uart_tx_en,
  uart_tx_model_if.slave              tx_if,
  input  logic                        uart_tx_break,
  output logic                        uart_txd,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int CPB   = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int CNT_W = $clog2(CPB * BREAK_BITS) + 1;
  localparam int BIT_W = $clog2(PAYLOAD_BITS);

  localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] STOP_RELOAD = CNT_W'(STOP_BITS * CPB - 1);
  localparam logic [CNT_W-1:0] BRK_RELOAD  = CNT_W'(BREAK_BITS * CPB - 1);
  localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(PAYLOAD_BITS - 1);

  if (!cfg_ok(PAYLOAD_BITS, STOP_BITS, CPB, FIFO_DEPTH)) begin : g_cfg_err
    $error("uart_tx_model: unsupported parameter combination");
  end

  tx_state_e               state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic                    txd_q, txd_d;
  logic                    brk_q, brk_d;
  logic                    launch;
  logic                    pop;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic [PAYLOAD_BITS-1:0] fifo_data;

  uart_tx_fifo #(
    .WIDTH (PAYLOAD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (resetn),
    .push_i  (tx_if.tx_valid),
    .data_i  (tx_if.tx_data),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign tx_if.tx_ready = !fifo_full;
  assign uart_txd       = txd_q;
  assign tx_busy        = (state_q != ST_IDLE) || !fifo_empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      brk_q   <= brk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    brk_d   = brk_q | uart_tx_break;
    launch  = 1'b0;
    pop     = 1'b0;

    unique case (state_q)
      ST_IDLE: launch = 1'b1;
      ST_START: begin
        if (cnt_q == '0) begin
          state_d = ST_DATA;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = '0;
          cnt_d   = BIT_RELOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          if (bit_q == LAST_BIT) begin
            state_d = ST_STOP;
            txd_d   = 1'b1;
            cnt_d   = STOP_RELOAD;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
            cnt_d   = BIT_RELOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == '0) launch = 1'b1;
        else             cnt_d  = cnt_q - CNT_W'(1);
      end
      ST_BREAK: begin
        if (cnt_q == '0) begin
          state_d = ST_BREAK_IDLE;
          txd_d   = 1'b1;
          cnt_d   = BIT_RELOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_BREAK_IDLE: begin
        if (cnt_q == '0) launch = 1'b1;
        else             cnt_d  = cnt_q - CNT_W'(1);
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase

    // Frame ends fall straight into the idle decision so consecutive frames
    // abut with no spare idle cycle.
    if (launch) begin
      if (brk_q) begin
        state_d = ST_BREAK;
        txd_d   = 1'b0;
        cnt_d   = BRK_RELOAD;
        brk_d   = 1'b0;
      end else if (uart_tx_en && !fifo_empty) begin
        pop     = 1'b1;
        shift_d = fifo_data;
        state_d = ST_START;
        txd_d   = 1'b0;
        cnt_d   = BIT_RELOAD;
      end else begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
